// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4 memory responder.
// Contents:
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   BURST_INCR              : the only supported burst type
//   SIZE_16B                : the only supported beat size (128-bit beats)
//   wstate_t / rstate_t     : write / read channel FSM states
//   req_err()               : flags an address request the responder rejects
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_16B    = 3'b100;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_16B) || (burst != BURST_INCR);
  endfunction

endpackage

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: one write port with byte enables, one synchronous
// read port. Read-first: a same-cycle write to the read address returns the
// previous contents. Contents are never reset.
// Ports:
//   clk             : clock
//   we/waddr/wdata  : write port, wstrb selects the bytes written
//   re/raddr/rdata  : read port, rdata updates only when re is high
module sdp_ram_be #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read and write share one process; the non-blocking read of mem picks up
  // the pre-write value, giving read-first behaviour on collisions.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a block RAM, for fast simulation of masters that
// normally talk to the DDR memory controller. Write and read channels run
// independently, one outstanding transaction each, INCR bursts of 16-byte
// beats only. Unsupported size/burst answers SLVERR (writes discarded, reads
// return zeros). Word index is addr[IDX_W+3:4]; higher bits alias.
// Ports:
//   ui_clk, ui_clk_sync_rst : clock, async active-high reset
//   s_axi_aw* / s_axi_w*    : write address / data channels
//   s_axi_b*                : write response channel
//   s_axi_ar* / s_axi_r*    : read address / data channels
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | wready high, accepting len+1 beats
// W_RESP  | bvalid high until bready
// R_IDLE  | arready high, waiting for a read address
// R_FETCH | RAM read issued for the current beat
// R_DATA  | rvalid high with RAM data held until rready
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 28,
  parameter int ID_WIDTH   = 2,
  parameter int DEPTH      = 1024
) (
  input  logic                    ui_clk,
  input  logic                    ui_clk_sync_rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int IDX_W = $clog2(DEPTH);

  wstate_t               w_state, w_state_nxt;
  rstate_t               r_state, r_state_nxt;
  logic                  rst_done;
  logic [ID_WIDTH-1:0]   w_id, r_id;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic [7:0]            w_len, w_beat, r_len, r_beat;
  logic                  w_cfg_err, w_err, r_err;
  logic                  aw_hs, w_hs, w_last_beat, ar_hs, r_hs, r_last_beat;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:IDX_W+4], s_axi_awaddr[3:0],
                              s_axi_araddr[ADDR_WIDTH-1:IDX_W+4], s_axi_araddr[3:0]};

  // Keeps awready/arready low while reset is held; they rise one cycle after release.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) rst_done <= 1'b0;
    else                 rst_done <= 1'b1;
  end

  // ---------------- write channel ----------------
  assign s_axi_awready = rst_done && (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bid     = w_id;
  assign s_axi_bresp   = w_err ? RESP_SLVERR : RESP_OKAY;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign w_last_beat   = (w_beat == w_len);

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_cfg_err <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        w_id      <= s_axi_awid;
        w_idx     <= s_axi_awaddr[IDX_W+3:4];
        w_len     <= s_axi_awlen;
        w_beat    <= '0;
        w_cfg_err <= req_err(s_axi_awsize, s_axi_awburst);
        w_err     <= req_err(s_axi_awsize, s_axi_awburst);
      end else if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        w_idx  <= w_idx + IDX_W'(1);
        // A misplaced wlast only flags the response; the beat count still ends the burst.
        if (s_axi_wlast != w_last_beat) w_err <= 1'b1;
      end
    end
  end

  // ---------------- read channel ----------------
  assign s_axi_arready = rst_done && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rid     = r_id;
  assign s_axi_rresp   = r_err ? RESP_SLVERR : RESP_OKAY;
  assign r_last_beat   = (r_beat == r_len);
  assign s_axi_rlast   = s_axi_rvalid && r_last_beat;
  // RAM output only moves in R_FETCH, so rdata is stable while a beat is stalled.
  assign s_axi_rdata   = (s_axi_rvalid && !r_err) ? ram_q : '0;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign r_hs          = s_axi_rvalid && s_axi_rready;

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
      R_FETCH: r_state_nxt = R_DATA;
      R_DATA:  if (r_hs) r_state_nxt = r_last_beat ? R_IDLE : R_FETCH;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        r_id   <= s_axi_arid;
        r_idx  <= s_axi_araddr[IDX_W+3:4];
        r_len  <= s_axi_arlen;
        r_beat <= '0;
        r_err  <= req_err(s_axi_arsize, s_axi_arburst);
      end else if (r_hs && !r_last_beat) begin
        r_beat <= r_beat + 8'd1;
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  sdp_ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (ui_clk),
    .we    (w_hs && !w_cfg_err),
    .waddr (w_idx),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (r_state == R_FETCH),
    .raddr (r_idx),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: drivers push expected B and R
// responses computed from a word-array memory model; a monitor pops and
// compares them at each handshake and checks the channel timing rules.
module tb_axi_mem_responder;

  logic         ui_clk;
  logic         ui_clk_sync_rst;
  logic [1:0]   s_axi_awid;
  logic [27:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic [2:0]   s_axi_awsize;
  logic [1:0]   s_axi_awburst;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [127:0] s_axi_wdata;
  logic [15:0]  s_axi_wstrb;
  logic         s_axi_wlast;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [1:0]   s_axi_arid;
  logic [27:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic [2:0]   s_axi_arsize;
  logic [1:0]   s_axi_arburst;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [1:0]   s_axi_rid;
  logic [127:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready;

  axi_mem_responder dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  localparam int DEPTH = 1024;

  int checks = 0;
  int failures = 0;
  int rr_mode = 0;  // 0: rready held high, 1: random, 2: toggling

  logic [127:0] mem_model [DEPTH];
  logic [127:0] wd [256];
  logic [15:0]  ws [256];
  logic [3:0]   b_exp [$];  // {bid, bresp}
  logic [132:0] r_exp [$];  // {rdata, rresp, rlast, rid}

  initial begin
    ui_clk = 1'b0;
    forever #5 ui_clk = ~ui_clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return s_axi_awready;
      1:       return s_axi_wready;
      default: return s_axi_arready;
    endcase
  endfunction

  task automatic wait_hi(input int which, input string name);
    int n = 0;
    while (!sel(which) && n < 200) begin
      @(negedge ui_clk);
      n++;
    end
    if (!sel(which)) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=0 required=1", name);
    end
  endtask

  task automatic axi_write(input logic [1:0] id, input logic [27:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bad_last, input int stop_after);
    bit cfg_err;
    bit lerr;
    int idx;
    int n;
    cfg_err = (size != 3'b100) || (burst != 2'b01);
    lerr = 1'b0;
    idx = int'(addr[13:4]);
    @(negedge ui_clk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    wait_hi(0, "awready");
    @(negedge ui_clk);
    s_axi_awvalid = 1'b0;
    chk("aw_to_wready", s_axi_wready, 1'b1);
    for (int b = 0; b <= len; b++) begin
      s_axi_wdata = wd[b];
      s_axi_wstrb = ws[b];
      s_axi_wlast = (bad_last >= 0) ? (b == bad_last) : (b == len);
      s_axi_wvalid = 1'b1;
      wait_hi(1, "wready");
      if (!cfg_err)
        for (int k = 0; k < 16; k++)
          if (ws[b][k]) mem_model[idx][k*8 +: 8] = wd[b][k*8 +: 8];
      if (s_axi_wlast != (b == len)) lerr = 1'b1;
      if (b == len) b_exp.push_back({id, (cfg_err || lerr) ? 2'b10 : 2'b00});
      idx = (idx + 1) % DEPTH;
      @(negedge ui_clk);
      if (b == stop_after) begin
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
        return;
      end
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast = 1'b0;
    chk("wlast_to_bvalid", {s_axi_wready, s_axi_bvalid}, 2'b01);
    n = 0;
    while (!(b_exp.size() == 0 && s_axi_awready) && n < 200) begin
      @(negedge ui_clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL timeout_bresp actual=pending required=done");
    end
  endtask

  task automatic axi_read(input logic [1:0] id, input logic [27:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit err;
    int idx;
    int n;
    logic rv1;
    err = (size != 3'b100) || (burst != 2'b01);
    idx = int'(addr[13:4]);
    for (int b = 0; b <= len; b++) begin
      r_exp.push_back({err ? 128'h0 : mem_model[idx], err ? 2'b10 : 2'b00, (b == len), id});
      idx = (idx + 1) % DEPTH;
    end
    @(negedge ui_clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    wait_hi(2, "arready");
    @(negedge ui_clk);
    s_axi_arvalid = 1'b0;
    rv1 = s_axi_rvalid;
    @(negedge ui_clk);
    chk("ar_to_rvalid", {rv1, s_axi_rvalid}, 2'b01);
    n = 0;
    while (!(r_exp.size() == 0 && s_axi_arready && !s_axi_rvalid) && n < 2000) begin
      @(negedge ui_clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL timeout_rdata actual=pending required=done");
    end
  endtask

  // Response-side ready drivers, changed just after the active edge.
  initial begin
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    forever begin
      @(posedge ui_clk);
      #1;
      s_axi_bready = 1'($urandom_range(0, 1));
      case (rr_mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = 1'($urandom_range(0, 1));
        default: s_axi_rready = ~s_axi_rready;
      endcase
    end
  end

  // Monitor: scoreboard pops and channel timing checks.
  initial begin : monitor
    logic [132:0] snap;
    logic [132:0] cur;
    logic [132:0] er;
    logic [3:0]   eb;
    bit stalled;
    bit ar_chk;
    bit aw_chk;
    int gap;
    stalled = 0; ar_chk = 0; aw_chk = 0; gap = 0; snap = '0;
    forever begin
      @(negedge ui_clk);
      if (ui_clk_sync_rst) begin
        stalled = 0; ar_chk = 0; aw_chk = 0; gap = 0;
      end else begin
        cur = {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid};
        if (aw_chk) begin
          chk("b_to_awready", {s_axi_awready, s_axi_bvalid}, 2'b10);
          aw_chk = 0;
        end
        if (ar_chk) begin
          chk("rlast_to_arready", {s_axi_arready, s_axi_rvalid}, 2'b10);
          ar_chk = 0;
        end
        if (gap == 1) begin
          chk("r_gap_low", s_axi_rvalid, 1'b0);
          gap = 2;
        end else if (gap == 2) begin
          chk("r_gap_high", s_axi_rvalid, 1'b1);
          gap = 0;
        end
        if (stalled) chk("r_stall_stable", {s_axi_rvalid, cur}, {1'b1, snap});
        stalled = 0;
        if (s_axi_rvalid && !s_axi_rready) begin
          stalled = 1;
          snap = cur;
        end
        if (s_axi_rvalid && s_axi_rready) begin
          if (r_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL r_unexpected actual=%0h required=none", cur);
          end else begin
            er = r_exp.pop_front();
            chk("r_beat", cur, er);
            if (er[2]) ar_chk = 1;
            else gap = 1;
          end
        end
        if (s_axi_bvalid && s_axi_bready) begin
          if (b_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected actual=%0h required=none", {s_axi_bid, s_axi_bresp});
          end else begin
            eb = b_exp.pop_front();
            chk("b_resp", {s_axi_bid, s_axi_bresp}, eb);
            aw_chk = 1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic fill_random(input int len, input bit full_strb);
    for (int b = 0; b <= len; b++) begin
      wd[b] = {$urandom, $urandom, $urandom, $urandom};
      ws[b] = (full_strb || $urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
               s_axi_rlast, s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp, s_axi_rdata}, '0);
  endtask

  initial begin
    ui_clk_sync_rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b100;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b100;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0;
    repeat (3) @(negedge ui_clk);
    chk_reset_outputs("reset_outputs");
    ui_clk_sync_rst = 1'b0;
    @(negedge ui_clk);
    chk("ready_after_reset", {s_axi_awready, s_axi_arready}, 2'b11);

    // Preload the whole RAM so every later read has a defined expectation.
    for (int p = 0; p < 4; p++) begin
      fill_random(255, 1'b1);
      axi_write(2'd0, 28'(p * 4096), 255, 3'b100, 2'b01, -1, -1);
    end

    // 16-beat CAFE pattern write and read-back.
    for (int i = 0; i < 16; i++) begin
      wd[i] = {104'b0, 16'hCAFE, 8'(i)};
      ws[i] = 16'hFFFF;
    end
    axi_write(2'b01, 28'h0, 15, 3'b100, 2'b01, -1, -1);
    axi_read(2'b01, 28'h0, 15, 3'b100, 2'b01);

    // Partial strobe over an all-ones word.
    wd[0] = {128{1'b1}}; ws[0] = 16'hFFFF;
    axi_write(2'd2, 28'h100, 0, 3'b100, 2'b01, -1, -1);
    wd[0] = {$urandom, $urandom, $urandom, $urandom}; ws[0] = 16'h00FF;
    axi_write(2'd2, 28'h100, 0, 3'b100, 2'b01, -1, -1);
    axi_read(2'd3, 28'h100, 0, 3'b100, 2'b01);

    // Early wlast: all beats taken and written, SLVERR response.
    fill_random(3, 1'b1);
    axi_write(2'd1, 28'h200, 3, 3'b100, 2'b01, 1, -1);
    axi_read(2'd0, 28'h200, 3, 3'b100, 2'b01);

    // Unsupported read size: zero data, SLVERR on each beat.
    axi_read(2'd2, 28'h300, 1, 3'b011, 2'b01);

    // Toggling rready on an 8-beat read.
    rr_mode = 2;
    axi_read(2'd2, 28'h0, 7, 3'b100, 2'b01);
    rr_mode = 0;

    // Index wrap from the top word, with high address bits that must alias away.
    fill_random(7, 1'b0);
    axi_write(2'd3, 28'hABC3FC0, 7, 3'b100, 2'b01, -1, -1);
    axi_read(2'd1, 28'h0003FC0, 7, 3'b100, 2'b01);

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      logic [27:0] a;
      int l;
      int bl;
      logic [2:0] sz;
      logic [1:0] bu;
      a  = 28'($urandom);
      l  = $urandom_range(0, 15);
      sz = ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b100;
      bu = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
      bl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, l)) : -1;
      fill_random(l, 1'b0);
      axi_write(2'($urandom), a, l, sz, bu, bl, -1);
      rr_mode = $urandom_range(0, 2);
      axi_read(2'($urandom), a, l, ($urandom_range(0, 9) == 0) ? 3'b101 : 3'b100, 2'b01);
    end
    rr_mode = 0;

    // Reset in the middle of a 16-beat write, after beat 5.
    fill_random(15, 1'b1);
    axi_write(2'd3, 28'h0, 15, 3'b100, 2'b01, -1, 5);
    ui_clk_sync_rst = 1'b1;
    @(negedge ui_clk);
    chk_reset_outputs("reset_mid_write");
    ui_clk_sync_rst = 1'b0;
    @(negedge ui_clk);
    chk("awready_after_release", s_axi_awready, 1'b1);
    fill_random(3, 1'b1);
    axi_write(2'd0, 28'h800, 3, 3'b100, 2'b01, -1, -1);
    axi_read(2'd1, 28'h50, 0, 3'b100, 2'b01);

    repeat (5) @(negedge ui_clk);
    chk("scoreboard_drained", {b_exp.size() == 0, r_exp.size() == 0}, 2'b11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
